// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// multicycle_control : FSM main control unit for a multicycle MIPS datapath
// Rev 1.0
// ============================================================================

module multicycle_control #(
  parameter int ADDI_EN = 1,
  parameter int TRAP_EN = 1,
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         opcode,
  input  logic               mem_ready,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               MemToReg,
  output logic               RegDst,
  output logic               regWrite,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ALUOp,
  output logic [1:0]         PCSource,
  output logic               instr_done,
  output logic               illegal,
  output logic [STATE_W-1:0] state_o
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    RWB    = 4'd7,
    BRANCH = 4'd8,
    JUMP   = 4'd9,
    ADDIEX = 4'd10,
    ADDIWB = 4'd11,
    TRAP   = 4'd12
  } state_t;

  state_t     state;
  state_t     next_state;
  logic [3:0] state_vis;

  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= next_state;
  end

  // Everything is decoded from the state register; reset masks all outputs.
  always_comb begin
    next_state  = state;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemToReg    = 1'b0;
    RegDst      = 1'b0;
    regWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    PCSource    = 2'b00;
    instr_done  = 1'b0;
    illegal     = 1'b0;
    if (!reset) begin
      case (state)
        FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = 2'b01;
          IRWrite = mem_ready;
          PCWrite = mem_ready;
          if (mem_ready) next_state = DECODE;
        end
        DECODE: begin
          ALUSrcB = 2'b11;
          if (opcode == OP_R)                            next_state = EXEC;
          else if (opcode == OP_LW || opcode == OP_SW)   next_state = MEMADR;
          else if (opcode == OP_BEQ)                     next_state = BRANCH;
          else if (opcode == OP_J)                       next_state = JUMP;
          else if (opcode == OP_ADDI && ADDI_EN != 0)    next_state = ADDIEX;
          else if (TRAP_EN != 0)                         next_state = TRAP;
          else begin
            // Illegal opcode retires as a NOP straight out of decode.
            next_state = FETCH;
            instr_done = 1'b1;
          end
        end
        MEMADR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
          if (opcode == OP_LW)      next_state = MEMRD;
          else if (opcode == OP_SW) next_state = MEMWR;
          else                      next_state = FETCH;
        end
        MEMRD: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
          if (mem_ready) next_state = MEMWB;
        end
        MEMWB: begin
          MemToReg   = 1'b1;
          regWrite   = 1'b1;
          instr_done = 1'b1;
          next_state = FETCH;
        end
        MEMWR: begin
          MemWrite   = 1'b1;
          IorD       = 1'b1;
          instr_done = mem_ready;
          if (mem_ready) next_state = FETCH;
        end
        EXEC: begin
          ALUSrcA    = 1'b1;
          ALUOp      = 2'b10;
          next_state = RWB;
        end
        RWB: begin
          RegDst     = 1'b1;
          regWrite   = 1'b1;
          instr_done = 1'b1;
          next_state = FETCH;
        end
        BRANCH: begin
          ALUSrcA     = 1'b1;
          ALUOp       = 2'b01;
          PCWriteCond = 1'b1;
          PCSource    = 2'b01;
          instr_done  = 1'b1;
          next_state  = FETCH;
        end
        JUMP: begin
          PCWrite    = 1'b1;
          PCSource   = 2'b10;
          instr_done = 1'b1;
          next_state = FETCH;
        end
        ADDIEX: begin
          ALUSrcA    = 1'b1;
          ALUSrcB    = 2'b10;
          next_state = ADDIWB;
        end
        ADDIWB: begin
          regWrite   = 1'b1;
          instr_done = 1'b1;
          next_state = FETCH;
        end
        TRAP: begin
          illegal = 1'b1;
        end
        default: next_state = FETCH;
      endcase
    end
  end

  assign state_vis = reset ? 4'd0 : 4'(state);

  if (STATE_W > 4) begin : g_state_wide
    assign state_o = {{(STATE_W-4){1'b0}}, state_vis};
  end else begin : g_state_exact
    assign state_o = state_vis;
  end

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
// tb_multicycle_control : scoreboard bench for multicycle_control
// Rev 1.0
// ============================================================================

module tb_multicycle_control;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  typedef struct packed {
    logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa;
    logic [1:0] asb, aop, pcs;
    logic idone, ill;
  } outs_t;

  typedef struct {
    int          sel;
    logic [3:0]  st;
    logic [17:0] o;
    int          cyc;
  } exp_t;

  typedef struct {
    logic [3:0] st;
    logic       mr;
    logic       idec;
  } step_t;

  logic        clk = 1'b0;
  logic [2:0]  rst_v = 3'b111;
  logic [5:0]  opcode = '0;
  logic        mem_ready = 1'b0;
  logic [17:0] ov [3];
  logic [3:0]  sv [3];

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  bit   running  = 0;

  always #5 clk = ~clk;

  // Instance 0: full features; 1: illegal retires as NOP; 2: addi disabled.
  for (genvar i = 0; i < 3; i++) begin : g_dut
    multicycle_control #(
      .ADDI_EN((i == 2) ? 0 : 1),
      .TRAP_EN((i == 1) ? 0 : 1),
      .STATE_W(4)
    ) u_dut (
      .clk(clk), .reset(rst_v[i]), .opcode(opcode), .mem_ready(mem_ready),
      .PCWrite(ov[i][17]), .PCWriteCond(ov[i][16]), .IorD(ov[i][15]),
      .MemRead(ov[i][14]), .MemWrite(ov[i][13]), .IRWrite(ov[i][12]),
      .MemToReg(ov[i][11]), .RegDst(ov[i][10]), .regWrite(ov[i][9]),
      .ALUSrcA(ov[i][8]), .ALUSrcB(ov[i][7:6]), .ALUOp(ov[i][5:4]),
      .PCSource(ov[i][3:2]), .instr_done(ov[i][1]), .illegal(ov[i][0]),
      .state_o(sv[i])
    );
  end

  // Control word the datapath should see for a given step of an instruction.
  function automatic logic [17:0] ctrl_of(logic [3:0] st, logic mr, logic idec);
    outs_t c;
    c = '0;
    case (st)
      4'd0:  begin c.mrd = 1; c.asb = 2'b01; c.irw = mr; c.pcw = mr; end
      4'd1:  begin c.asb = 2'b11; c.idone = idec; end
      4'd2:  begin c.asa = 1; c.asb = 2'b10; end
      4'd3:  begin c.mrd = 1; c.iord = 1; end
      4'd4:  begin c.m2r = 1; c.rw = 1; c.idone = 1; end
      4'd5:  begin c.mwr = 1; c.iord = 1; c.idone = mr; end
      4'd6:  begin c.asa = 1; c.aop = 2'b10; end
      4'd7:  begin c.rdst = 1; c.rw = 1; c.idone = 1; end
      4'd8:  begin c.asa = 1; c.aop = 2'b01; c.pcwc = 1; c.pcs = 2'b01; c.idone = 1; end
      4'd9:  begin c.pcw = 1; c.pcs = 2'b10; c.idone = 1; end
      4'd10: begin c.asa = 1; c.asb = 2'b10; end
      4'd11: begin c.rw = 1; c.idone = 1; end
      4'd12: begin c.ill = 1; end
      default: c = '0;
    endcase
    return c;
  endfunction

  task automatic do_cycle(input int sel, input bit r, input logic [5:0] op,
                          input bit mr, input logic [3:0] st, input logic [17:0] o);
    exp_t e;
    rst_v = 3'b111;
    if (!r) rst_v[sel] = 1'b0;
    opcode    = op;
    mem_ready = mr;
    e.sel = sel; e.st = st; e.o = o; e.cyc = cyc;
    sb.push_back(e);
    running = 1;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic reset_cycles(input int sel, input int n);
    repeat (n) do_cycle(sel, 1'b1, opcode, 1'($urandom_range(0, 1)), 4'd0, 18'd0);
  endtask

  // Builds the step list of one instruction from its opcode class, then plays it.
  // wm = memory wait cycles (or extra TRAP cycles); cut = step index replaced by reset.
  task automatic run_instr(input int sel, input logic [5:0] op, input int wf,
                           input int wm, input int cut);
    step_t seq[$];
    bit addi_en, trap_en, legal, trapped;
    addi_en = (sel != 2);
    trap_en = (sel != 1);
    trapped = 0;
    legal = (op == OP_R) || (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ) ||
            (op == OP_J) || (op == OP_ADDI && addi_en);
    repeat (wf) seq.push_back('{4'd0, 1'b0, 1'b0});
    seq.push_back('{4'd0, 1'b1, 1'b0});
    seq.push_back('{4'd1, 1'($urandom_range(0, 1)), !legal && !trap_en});
    if (!legal) begin
      if (trap_en) begin
        trapped = 1;
        repeat (wm + 1) seq.push_back('{4'd12, 1'($urandom_range(0, 1)), 1'b0});
      end
    end else begin
      case (op)
        OP_R: begin
          seq.push_back('{4'd6, 1'($urandom_range(0, 1)), 1'b0});
          seq.push_back('{4'd7, 1'($urandom_range(0, 1)), 1'b0});
        end
        OP_LW: begin
          seq.push_back('{4'd2, 1'($urandom_range(0, 1)), 1'b0});
          repeat (wm) seq.push_back('{4'd3, 1'b0, 1'b0});
          seq.push_back('{4'd3, 1'b1, 1'b0});
          seq.push_back('{4'd4, 1'($urandom_range(0, 1)), 1'b0});
        end
        OP_SW: begin
          seq.push_back('{4'd2, 1'($urandom_range(0, 1)), 1'b0});
          repeat (wm) seq.push_back('{4'd5, 1'b0, 1'b0});
          seq.push_back('{4'd5, 1'b1, 1'b0});
        end
        OP_BEQ: seq.push_back('{4'd8, 1'($urandom_range(0, 1)), 1'b0});
        OP_J:   seq.push_back('{4'd9, 1'($urandom_range(0, 1)), 1'b0});
        default: begin
          seq.push_back('{4'd10, 1'($urandom_range(0, 1)), 1'b0});
          seq.push_back('{4'd11, 1'($urandom_range(0, 1)), 1'b0});
        end
      endcase
    end
    for (int i = 0; i < seq.size(); i++) begin
      if (i == cut) begin
        reset_cycles(sel, 1);
        return;
      end
      do_cycle(sel, 1'b0, op, seq[i].mr, seq[i].st, ctrl_of(seq[i].st, seq[i].mr, seq[i].idec));
    end
    if (trapped) reset_cycles(sel, 1);
  endtask

  function automatic logic [5:0] pick_op();
    case ($urandom_range(0, 6))
      0: return OP_R;
      1: return OP_LW;
      2: return OP_SW;
      3: return OP_BEQ;
      4: return OP_J;
      5: return OP_ADDI;
      default: return 6'($urandom);
    endcase
  endfunction

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      n_checks++;
      if (sv[mon_e.sel] !== mon_e.st) begin
        n_fail++;
        $display("FAIL state dut%0d cycle %0d: got %0d expected %0d",
                 mon_e.sel, mon_e.cyc, sv[mon_e.sel], mon_e.st);
      end
      n_checks++;
      if (ov[mon_e.sel] !== mon_e.o) begin
        n_fail++;
        $display("FAIL ctrl dut%0d cycle %0d state %0d: got %b expected %b",
                 mon_e.sel, mon_e.cyc, mon_e.st, ov[mon_e.sel], mon_e.o);
      end
    end else if (running) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard empty at cycle %0d: got 0 entries expected 1", cyc);
    end
  end

  initial begin
    @(posedge clk);
    #1;
    // Full-featured instance: directed instructions, then random traffic.
    reset_cycles(0, 2);
    run_instr(0, OP_R,    0, 0, -1);
    run_instr(0, OP_LW,   0, 3, -1);
    run_instr(0, OP_SW,   0, 0, -1);
    run_instr(0, OP_BEQ,  0, 0, -1);
    run_instr(0, OP_J,    0, 0, -1);
    run_instr(0, OP_ADDI, 1, 0, -1);
    run_instr(0, 6'b111111, 0, 9, -1);
    run_instr(0, OP_SW,   0, 2, 3);
    run_instr(0, OP_R,    2, 0, -1);
    for (int n = 0; n < 150; n++) begin
      run_instr(0, pick_op(), int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 6)) : -1);
    end
    // Illegal-as-NOP instance.
    reset_cycles(1, 2);
    run_instr(1, 6'b111111, 0, 0, -1);
    run_instr(1, OP_R,    0, 0, -1);
    run_instr(1, OP_ADDI, 0, 0, -1);
    for (int n = 0; n < 30; n++)
      run_instr(1, pick_op(), int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), -1);
    // addi-disabled instance.
    reset_cycles(2, 2);
    run_instr(2, OP_ADDI, 0, 4, -1);
    run_instr(2, OP_LW,   0, 1, -1);
    for (int n = 0; n < 30; n++)
      run_instr(2, pick_op(), int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), -1);
    running = 0;
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
